// File: rtl/nor_seq_ctrl.sv
// Microprogrammed sequencer that evaluates a selectable Boolean function
// through one shared WIDTH-bit NOR cell over a 4-entry scratch file.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   start, op, a, b  request, function select (7 = illegal), operands
//   busy, done, err  executing flag, one-cycle completion pulse, illegal-op flag
//   y                result, held until the next done
//   step             index of the step executing next (0 outside RUN)
//   nor_count        saturating count of executed NOR steps
module nor_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       step,
    output logic [15:0]      nor_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rf [4];
    logic [2:0]       op_q;
    logic [2:0]       step_q;
    logic             busy_q, done_q, err_q;
    logic [WIDTH-1:0] y_q;
    logic [15:0]      nor_cnt_q;

    logic [1:0]       src1, src2, dst;
    logic [2:0]       last;
    logic             accept, finish, illegal;
    logic [WIDTH-1:0] nor_out;

    // Microprogram: operand/destination selects and final step per op.
    always_comb begin
        src1 = 2'd0;
        src2 = 2'd0;
        dst  = 2'd2;
        last = 3'd0;
        unique case (op_q)
            3'd0: begin
                src1 = 2'd0; src2 = 2'd1;
            end
            3'd1: begin
                last = 3'd1;
                if (step_q == 3'd0) begin
                    src1 = 2'd0; src2 = 2'd1;
                end else begin
                    src1 = 2'd2; src2 = 2'd2;
                end
            end
            3'd2: begin
                src1 = 2'd0; src2 = 2'd0;
            end
            3'd3, 3'd4: begin
                last = (op_q == 3'd3) ? 3'd2 : 3'd3;
                unique case (step_q)
                    3'd0: begin src1 = 2'd0; src2 = 2'd0; end
                    3'd1: begin src1 = 2'd1; src2 = 2'd1; dst = 2'd3; end
                    3'd2: begin src1 = 2'd2; src2 = 2'd3; end
                    default: begin src1 = 2'd2; src2 = 2'd2; end
                endcase
            end
            3'd5, 3'd6: begin
                last = (op_q == 3'd5) ? 3'd3 : 3'd4;
                unique case (step_q)
                    3'd0: begin src1 = 2'd0; src2 = 2'd1; end
                    3'd1: begin src1 = 2'd0; src2 = 2'd2; dst = 2'd3; end
                    3'd2: begin src1 = 2'd1; src2 = 2'd2; end
                    3'd3: begin src1 = 2'd3; src2 = 2'd2; end
                    default: begin src1 = 2'd2; src2 = 2'd2; end
                endcase
            end
            default: begin
                last = 3'd0;
            end
        endcase
    end

    assign nor_out = ~(rf[src1] | rf[src2]);
    assign illegal = (op_q == 3'd7);

    // Next state and handshake decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = start;
                if (start) state_d = RUN;
            end
            RUN: begin
                finish = illegal || (step_q == last);
                if (finish) state_d = DONE;
            end
            DONE: begin
                accept  = start;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            op_q      <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            y_q       <= '0;
            nor_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                rf[0]  <= a;
                rf[1]  <= b;
                rf[2]  <= '0;
                rf[3]  <= '0;
                op_q   <= op;
                busy_q <= 1'b1;
                err_q  <= 1'b0;
                step_q <= '0;
            end else if (state_q == RUN) begin
                // The illegal op burns one cycle without using the cell.
                if (!illegal) begin
                    rf[dst] <= nor_out;
                    if (nor_cnt_q != 16'hFFFF)
                        nor_cnt_q <= nor_cnt_q + 16'd1;
                end
                if (finish) begin
                    y_q    <= illegal ? '0 : nor_out;
                    err_q  <= illegal;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    step_q <= '0;
                end else begin
                    step_q <= step_q + 3'd1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign y         = y_q;
    assign step      = step_q;
    assign nor_count = nor_cnt_q;

endmodule

// File: tb/tb_nor_seq_ctrl.sv
// Self-checking bench for nor_seq_ctrl: scoreboard of expected results
// pushed at issue and popped at done, one task per scenario.
module tb_nor_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [3:0] a, b;
    logic       busy, done, err;
    logic [3:0] y;
    logic [2:0] step;
    logic [15:0] nor_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  y;
        logic        err;
        int          lat;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    logic [15:0] exp_cnt = 16'd0;

    nor_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .err(err),
        .y(y), .step(step), .nor_count(nor_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_y(input logic [2:0] o,
                                           input logic [3:0] x,
                                           input logic [3:0] z);
        case (o)
            3'd0: model_y = ~(x | z);
            3'd1: model_y = x | z;
            3'd2: model_y = ~x;
            3'd3: model_y = x & z;
            3'd4: model_y = ~(x & z);
            3'd5: model_y = ~(x ^ z);
            3'd6: model_y = x ^ z;
            default: model_y = 4'd0;
        endcase
    endfunction

    function automatic int model_n(input logic [2:0] o);
        case (o)
            3'd0: model_n = 1;
            3'd1: model_n = 2;
            3'd2: model_n = 1;
            3'd3: model_n = 3;
            3'd4: model_n = 4;
            3'd5: model_n = 4;
            3'd6: model_n = 5;
            default: model_n = 1;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [3:0] x,
                         input logic [3:0] z);
        exp_t e;
        if (o != 3'd7)
            for (int i = 0; i < model_n(o); i++)
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.y   = model_y(o, x, z);
        e.err = (o == 3'd7);
        e.lat = model_n(o);
        e.cnt = exp_cnt;
        sb.push_back(e);
        op = o; a = x; b = z; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (y !== 4'd0) begin bad++; $display("FAIL rst_y got=%b exp=0000", y); end
        total++; if (step !== 3'd0) begin bad++; $display("FAIL rst_step got=%0d exp=0", step); end
        total++; if (nor_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0000", nor_count); end
    endtask

    task automatic test_and;
        exp_t e;
        issue(3'd3, 4'b0011, 4'b0101);
        total++; if (busy !== 1'b1 || step !== 3'd0) begin
            bad++; $display("FAIL and_e0 busy=%b step=%0d exp busy=1 step=0", busy, step);
        end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b1 || done !== 1'b0 || step !== 3'(k)) begin
                bad++; $display("FAIL and_run%0d busy=%b done=%b step=%0d exp 1 0 %0d", k, busy, done, step, k);
            end
        end
        @(negedge clk);
        e = sb.pop_front();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL and_done done=%b busy=%b exp 1 0", done, busy);
        end
        total++; if (y !== e.y) begin bad++; $display("FAIL and_y got=%b exp=%b", y, e.y); end
        total++; if (nor_count !== e.cnt) begin bad++; $display("FAIL and_cnt got=%0d exp=%0d", nor_count, e.cnt); end
        @(negedge clk);
        total++; if (done !== 1'b0 || y !== e.y) begin
            bad++; $display("FAIL and_pulse done=%b y=%b exp 0 %b", done, y, e.y);
        end
    endtask

    task automatic test_ops;
        logic [2:0] ops [4];
        exp_t e;
        int lat;
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd4;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 4'b0011, 4'b0101);
            wait_done(20, lat);
            e = sb.pop_front();
            total++; if (lat !== e.lat) begin bad++; $display("FAIL ops%0d_lat got=%0d exp=%0d", ops[i], lat, e.lat); end
            total++; if (y !== e.y || err !== e.err) begin
                bad++; $display("FAIL ops%0d_y got=%b/%b exp=%b/%b", ops[i], y, err, e.y, e.err);
            end
            total++; if (nor_count !== e.cnt) begin bad++; $display("FAIL ops%0d_cnt got=%0d exp=%0d", ops[i], nor_count, e.cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int lat;
        issue(3'd6, 4'b0011, 4'b0101);
        wait_done(20, lat);
        e = sb.pop_front();
        total++; if (lat !== e.lat || y !== e.y) begin
            bad++; $display("FAIL xor lat=%0d y=%b exp %0d %b", lat, y, e.lat, e.y);
        end
        issue(3'd5, 4'b0011, 4'b0101);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
        wait_done(20, lat);
        e = sb.pop_front();
        total++; if (lat !== e.lat || y !== e.y) begin
            bad++; $display("FAIL xnor lat=%0d y=%b exp %0d %b", lat, y, e.lat, e.y);
        end
        total++; if (nor_count !== e.cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", nor_count, e.cnt); end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        exp_t e;
        int lat;
        issue(3'd7, 4'b1010, 4'b0110);
        wait_done(20, lat);
        e = sb.pop_front();
        total++; if (lat !== e.lat || err !== e.err || y !== e.y) begin
            bad++; $display("FAIL ill lat=%0d err=%b y=%b exp %0d %b %b", lat, err, y, e.lat, e.err, e.y);
        end
        total++; if (nor_count !== e.cnt) begin bad++; $display("FAIL ill_cnt got=%0d exp=%0d", nor_count, e.cnt); end
        repeat (2) @(negedge clk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_hold err=%b exp=1", err); end
        issue(3'd0, 4'b1010, 4'b0110);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_clear err=%b exp=0", err); end
        wait_done(20, lat);
        e = sb.pop_front();
        total++; if (lat !== e.lat || y !== e.y || nor_count !== e.cnt) begin
            bad++; $display("FAIL post_ill lat=%0d y=%b cnt=%0d exp %0d %b %0d", lat, y, nor_count, e.lat, e.y, e.cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore;
        exp_t e;
        int lat;
        issue(3'd6, 4'b0011, 4'b0101);
        @(negedge clk);
        op = 3'd0; a = 4'b1111; b = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, lat);
        if (lat > 0) lat = lat + 2;
        e = sb.pop_front();
        total++; if (lat !== e.lat || y !== e.y) begin
            bad++; $display("FAIL ignore lat=%0d y=%b exp %0d %b", lat, y, e.lat, e.y);
        end
        total++; if (nor_count !== e.cnt) begin bad++; $display("FAIL ignore_cnt got=%0d exp=%0d", nor_count, e.cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        issue(3'd6, 4'b0011, 4'b0101);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_cnt = 16'd0;
        total++; if ({busy, done, err} !== 3'b000 || y !== 4'd0 || step !== 3'd0 || nor_count !== exp_cnt) begin
            bad++; $display("FAIL mid_rst b/d/e=%b%b%b y=%b step=%0d cnt=%0d exp 000 0000 0 0", busy, done, err, y, step, nor_count);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_done got=%0d exp=0", seen); end
    endtask

    task automatic test_saturate;
        exp_t e;
        int lat;
        force dut.nor_cnt_q = 16'hFFFE;
        #1;
        release dut.nor_cnt_q;
        exp_cnt = 16'hFFFE;
        issue(3'd3, 4'b0011, 4'b0101);
        wait_done(20, lat);
        e = sb.pop_front();
        total++; if (nor_count !== e.cnt) begin bad++; $display("FAIL sat_cnt got=%h exp=%h", nor_count, e.cnt); end
        total++; if (y !== e.y) begin bad++; $display("FAIL sat_y got=%b exp=%b", y, e.y); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_and;
        test_ops;
        test_back_to_back;
        test_illegal;
        test_ignore;
        test_reset_mid;
        test_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
